// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM states and interrupt type codes.
package interrupt_controller_pkg;

    // Interrupt type codes reported on interr_type (zero-extended).
    localparam logic [1:0] IntNone  = 2'd0;
    localparam logic [1:0] IntTimer = 2'd1;
    localparam logic [1:0] IntHalt  = 2'd2;

    // Controller mode: kernel code, user process, or one-cycle trap to the OS vector.
    typedef enum logic [1:0] {
        StKernel = 2'd0,
        StUser   = 2'd1,
        StTrap   = 2'd2
    } ic_state_e;

endpackage

// File: rtl/interrupt_controller_quantum_timer.sv
// Time-slice down-counter: loads a quantum, decrements once per enable (saturating at 0),
// and flags the last instruction of the slice.
module interrupt_controller_quantum_timer #(
    parameter int unsigned TIMER_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    input  logic                   dec,
    output logic [TIMER_WIDTH-1:0] count,
    output logic                   expire
);

    logic [TIMER_WIDTH-1:0] count_q;

    // Counter register: load has priority over decrement; never wraps below zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - TIMER_WIDTH'(1);
        end
    end

    // Expiry marks the retire that consumes the final instruction of the slice.
    always_comb begin
        count  = count_q;
        expire = (count_q == TIMER_WIDTH'(1));
    end

endmodule

// File: rtl/interrupt_controller.sv
// OS/interrupt command responder: owns user/kernel mode, the quantum timer, the trap
// handshake to the datapath, and the saved/return PCs and interrupt type.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             TIMER_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   OS_VECTOR   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_en,
    input  logic                   set_clock,
    input  logic [TIMER_WIDTH-1:0] timer_value,
    input  logic                   os_jump_to,
    input  logic                   os_save_return,
    input  logic                   get_interruption,
    input  logic                   halt,
    input  logic [ADDR_WIDTH-1:0]  pc_current,
    input  logic [ADDR_WIDTH-1:0]  pc_next,
    output logic                   irq_take,
    output logic                   user_mode,
    output logic [ADDR_WIDTH-1:0]  saved_pc,
    output logic [ADDR_WIDTH-1:0]  return_pc,
    output logic [ADDR_WIDTH-1:0]  interr_type
);

    ic_state_e              state_q, state_d;
    logic [TIMER_WIDTH-1:0] quantum_q, quantum_d;
    logic [ADDR_WIDTH-1:0]  saved_pc_q, saved_pc_d;
    logic [ADDR_WIDTH-1:0]  return_pc_q, return_pc_d;
    logic [1:0]             type_q, type_d;

    logic                   timer_load;
    logic                   timer_dec;
    logic                   timer_expire;
    logic [TIMER_WIDTH-1:0] timer_count;
    logic                   trap_halt;
    logic                   trap_timer;

    // The OS vector itself is applied by the datapath; it is only carried here.
    logic unused_os_vector;
    assign unused_os_vector = ^{OS_VECTOR, timer_count};

    interrupt_controller_quantum_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_quantum_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (quantum_q),
        .dec        (timer_dec),
        .count      (timer_count),
        .expire     (timer_expire)
    );

    // Trap conditions in USER; halt takes priority over a coincident expiry.
    always_comb begin
        trap_halt  = (state_q == StUser) && cpu_en && halt;
        trap_timer = (state_q == StUser) && cpu_en && !halt &&
                     (quantum_q != '0) && timer_expire;
        timer_load = (state_q == StKernel) && cpu_en && os_jump_to;
        timer_dec  = (state_q == StUser) && cpu_en;
    end

    // Next-state and register updates; everything waits for a retire except leaving TRAP.
    always_comb begin
        state_d     = state_q;
        quantum_d   = quantum_q;
        saved_pc_d  = saved_pc_q;
        return_pc_d = return_pc_q;
        type_d      = type_q;

        if (cpu_en && get_interruption) begin
            type_d = IntNone;
        end

        unique case (state_q)
            StKernel: begin
                if (cpu_en) begin
                    if (set_clock) begin
                        quantum_d = timer_value;
                    end
                    if (os_save_return) begin
                        return_pc_d = pc_current + ADDR_WIDTH'(1);
                    end
                    if (os_jump_to) begin
                        state_d = StUser;
                    end
                end
            end
            StUser: begin
                if (cpu_en && set_clock) begin
                    quantum_d = timer_value;
                end
                if (trap_halt) begin
                    state_d    = StTrap;
                    type_d     = IntHalt;
                    saved_pc_d = pc_current;
                end else if (trap_timer) begin
                    state_d    = StTrap;
                    type_d     = IntTimer;
                    saved_pc_d = pc_next;
                end
            end
            StTrap: begin
                state_d = StKernel;
            end
            default: begin
                state_d = StKernel;
            end
        endcase
    end

    // State and data registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StKernel;
            quantum_q   <= '0;
            saved_pc_q  <= '0;
            return_pc_q <= '0;
            type_q      <= IntNone;
        end else begin
            state_q     <= state_d;
            quantum_q   <= quantum_d;
            saved_pc_q  <= saved_pc_d;
            return_pc_q <= return_pc_d;
            type_q      <= type_d;
        end
    end

    // Outputs decoded straight from registers so reset clears them immediately.
    always_comb begin
        irq_take    = (state_q == StTrap);
        user_mode   = (state_q == StUser);
        saved_pc    = saved_pc_q;
        return_pc   = return_pc_q;
        interr_type = {{(ADDR_WIDTH - 2){1'b0}}, type_q};
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

    logic        clock;
    logic        reset;
    logic        cpu_en;
    logic        set_clock;
    logic [31:0] timer_value;
    logic        os_jump_to;
    logic        os_save_return;
    logic        get_interruption;
    logic        halt;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        irq_take;
    logic        user_mode;
    logic [31:0] saved_pc;
    logic [31:0] return_pc;
    logic [31:0] interr_type;

    int checks = 0;
    int errors = 0;
    int irq_seen;

    interrupt_controller #(
        .ADDR_WIDTH  (32),
        .TIMER_WIDTH (32),
        .OS_VECTOR   (32'h0)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_en           (cpu_en),
        .set_clock        (set_clock),
        .timer_value      (timer_value),
        .os_jump_to       (os_jump_to),
        .os_save_return   (os_save_return),
        .get_interruption (get_interruption),
        .halt             (halt),
        .pc_current       (pc_current),
        .pc_next          (pc_next),
        .irq_take         (irq_take),
        .user_mode        (user_mode),
        .saved_pc         (saved_pc),
        .return_pc        (return_pc),
        .interr_type      (interr_type)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_cmds();
        cpu_en           = 1'b0;
        set_clock        = 1'b0;
        os_jump_to       = 1'b0;
        os_save_return   = 1'b0;
        get_interruption = 1'b0;
        halt             = 1'b0;
    endtask

    // One retire with whatever command strobes are currently set; sample 1 ns after the edge.
    task automatic step();
        cpu_en = 1'b1;
        @(posedge clock);
        #1;
        clear_cmds();
    endtask

    // One clock without a retire.
    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    task automatic load_quantum(input logic [31:0] q);
        set_clock   = 1'b1;
        timer_value = q;
        step();
    endtask

    task automatic enter_user();
        os_jump_to = 1'b1;
        step();
    endtask

    initial begin
        clear_cmds();
        timer_value = '0;
        pc_current  = '0;
        pc_next     = '0;
        reset       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_irq", {63'd0, irq_take}, 64'd0);
        check("rst_user", {63'd0, user_mode}, 64'd0);
        check("rst_saved", {32'd0, saved_pc}, 64'd0);
        check("rst_ret", {32'd0, return_pc}, 64'd0);
        check("rst_type", {32'd0, interr_type}, 64'd0);
        reset = 1'b1;
        idle();

        // Timer expiry after three retires.
        load_quantum(32'd3);
        enter_user();
        check("t2_user", {63'd0, user_mode}, 64'd1);
        pc_next = 32'h40;
        step();
        step();
        check("t2_noirq", {63'd0, irq_take}, 64'd0);
        step();
        check("t2_irq", {63'd0, irq_take}, 64'd1);
        check("t2_user0", {63'd0, user_mode}, 64'd0);
        check("t2_saved", {32'd0, saved_pc}, 64'h40);
        check("t2_type", {32'd0, interr_type}, 64'd1);
        idle();
        check("t2_irq_once", {63'd0, irq_take}, 64'd0);
        check("t2_kernel", {63'd0, user_mode}, 64'd0);

        // Read-to-clear and return address wrap.
        check("t6_type_rd", {32'd0, interr_type}, 64'd1);
        get_interruption = 1'b1;
        step();
        check("t6_type_clr", {32'd0, interr_type}, 64'd0);
        pc_current     = 32'h10;
        os_save_return = 1'b1;
        step();
        check("t6_ret_inc", {32'd0, return_pc}, 64'h11);
        pc_current     = 32'hFFFF_FFFF;
        os_save_return = 1'b1;
        step();
        check("t6_ret_wrap", {32'd0, return_pc}, 64'd0);

        // Halt coincides with expiry: halt wins.
        load_quantum(32'd2);
        enter_user();
        step();
        pc_current = 32'h30;
        pc_next    = 32'h31;
        halt       = 1'b1;
        step();
        check("t4_irq", {63'd0, irq_take}, 64'd1);
        check("t4_type", {32'd0, interr_type}, 64'd2);
        check("t4_saved", {32'd0, saved_pc}, 64'h30);
        idle();
        get_interruption = 1'b1;
        step();
        check("t4_clr", {32'd0, interr_type}, 64'd0);

        // Halt in USER with a long quantum; no timer trap afterwards.
        load_quantum(32'd10);
        enter_user();
        pc_current = 32'h20;
        pc_next    = 32'h21;
        step();
        pc_current = 32'h22;
        pc_next    = 32'h23;
        halt       = 1'b1;
        step();
        check("t3_irq", {63'd0, irq_take}, 64'd1);
        check("t3_saved", {32'd0, saved_pc}, 64'h22);
        check("t3_type", {32'd0, interr_type}, 64'd2);
        irq_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (irq_take) irq_seen++;
        end
        check("t3_no_timer", irq_seen, 0);

        // Quantum zero disables the timer entirely.
        load_quantum(32'd0);
        enter_user();
        irq_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (irq_take) irq_seen++;
        end
        check("t5_no_irq", irq_seen, 0);
        check("t5_still_user", {63'd0, user_mode}, 64'd1);
        halt = 1'b1;
        step();
        check("t5_halt_exit", {63'd0, irq_take}, 64'd1);
        idle();

        // Reset asserted while in TRAP.
        load_quantum(32'd1);
        enter_user();
        pc_next = 32'h55;
        step();
        check("t1_trap", {63'd0, irq_take}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t1_irq_async", {63'd0, irq_take}, 64'd0);
        check("t1_user_async", {63'd0, user_mode}, 64'd0);
        check("t1_saved", {32'd0, saved_pc}, 64'd0);
        check("t1_type", {32'd0, interr_type}, 64'd0);
        idle();
        reset = 1'b1;
        idle();
        idle();
        check("t1_irq_post", {63'd0, irq_take}, 64'd0);
        check("t1_user_post", {63'd0, user_mode}, 64'd0);
        check("t1_ret_post", {32'd0, return_pc}, 64'd0);
        // Back in KERNEL: a jump enters USER again.
        enter_user();
        check("t1_kernel_jump", {63'd0, user_mode}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
